// File: rtl/imager_pkg.sv
// Shared types and default widths for the imager pipeline blocks.
package imager_pkg;

  localparam int unsigned DATA_WIDTH     = 10;
  localparam int unsigned NUM_ROWS_WIDTH = 12;
  localparam int unsigned NUM_COLS_WIDTH = 12;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2
  } state_t;

endpackage

// File: rtl/imager_crop_window.sv
// Range compare for one crop axis: hit when start <= cnt < start+len.
// Bounds are formed one bit wider than start/len so start+len never wraps.
module imager_crop_window #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] start,
  input  logic [W-1:0] len,
  input  logic [W:0]   cnt,
  output logic         hit_c
);

  logic [W:0] lo;
  logic [W:0] hi;

  assign lo    = (W+1)'(start);
  assign hi    = (W+1)'(start) + (W+1)'(len);
  assign hit_c = (cnt >= lo) && (cnt < hi);

endmodule

// File: rtl/imager_crop.sv
// Region-of-interest crop and frame-geometry measurement for the imager stream.
// Optional IMAGER_CROP_CHECKSUM_EN adds a per-frame rotate/xor checksum of the cropped pixels.
module imager_crop #(
  parameter int unsigned DATA_WIDTH     = imager_pkg::DATA_WIDTH,
  parameter int unsigned NUM_ROWS_WIDTH = imager_pkg::NUM_ROWS_WIDTH,
  parameter int unsigned NUM_COLS_WIDTH = imager_pkg::NUM_COLS_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      crop_en,
  input  logic [NUM_ROWS_WIDTH-1:0] crop_row_start,
  input  logic [NUM_ROWS_WIDTH-1:0] crop_rows,
  input  logic [NUM_COLS_WIDTH-1:0] crop_col_start,
  input  logic [NUM_COLS_WIDTH-1:0] crop_cols,
  input  logic [DATA_WIDTH-1:0]     dat_i,
  input  logic                      fv_i,
  input  logic                      lv_i,
  output logic [DATA_WIDTH-1:0]     dat_o,
  output logic                      fv_o,
  output logic                      lv_o,
  output logic [NUM_ROWS_WIDTH:0]   meas_rows,
  output logic [NUM_COLS_WIDTH:0]   meas_cols,
  output logic                      meas_valid,
  output logic                      line_len_err
`ifdef IMAGER_CROP_CHECKSUM_EN
  ,
  output logic [31:0]               crop_checksum
`endif
);
  import imager_pkg::*;

  localparam int unsigned RW = NUM_ROWS_WIDTH + 1;
  localparam int unsigned CW = NUM_COLS_WIDTH + 1;

  state_t state, state_nxt;

  logic                      frame_start, frame_act, frame_end;
  logic                      lv_eff, lv_q, line_end, mismatch;
  logic [RW-1:0]             row_cnt, row_inc;
  logic [CW-1:0]             col_cnt, col_inc, first_len;
  logic                      len_err;
  logic                      sh_en;
  logic [NUM_ROWS_WIDTH-1:0] sh_row_start, sh_rows;
  logic [NUM_COLS_WIDTH-1:0] sh_col_start, sh_cols;
  logic                      cfg_en;
  logic [NUM_ROWS_WIDTH-1:0] cfg_row_start, cfg_rows;
  logic [NUM_COLS_WIDTH-1:0] cfg_col_start, cfg_cols;
  logic                      row_hit_c, col_hit_c, hit;
  logic                      fv_d, lv_d;
  logic [DATA_WIDTH-1:0]     dat_d;

  assign frame_start = (state == IDLE) && fv_i;
  assign frame_act   = frame_start || ((state == FRAME) && fv_i);
  assign frame_end   = (state == FRAME) && !fv_i;
  assign lv_eff      = lv_i && frame_act;
  // A line ends on lv falling or when fv drops under a still-high lv.
  assign line_end    = lv_q && !lv_eff;
  assign mismatch    = line_end && (row_cnt != '0) && (col_cnt != first_len);
  assign row_inc     = (row_cnt == '1) ? row_cnt : row_cnt + RW'(1);
  assign col_inc     = (col_cnt == '1) ? col_cnt : col_cnt + CW'(1);

  // Live config is used on the frame-start cycle, the shadow copy afterwards.
  assign cfg_en        = frame_start ? crop_en        : sh_en;
  assign cfg_row_start = frame_start ? crop_row_start : sh_row_start;
  assign cfg_rows      = frame_start ? crop_rows      : sh_rows;
  assign cfg_col_start = frame_start ? crop_col_start : sh_col_start;
  assign cfg_cols      = frame_start ? crop_cols      : sh_cols;

  imager_crop_window #(.W(NUM_ROWS_WIDTH)) u_row_win (
    .start (cfg_row_start),
    .len   (cfg_rows),
    .cnt   (row_cnt),
    .hit_c (row_hit_c)
  );

  imager_crop_window #(.W(NUM_COLS_WIDTH)) u_col_win (
    .start (cfg_col_start),
    .len   (cfg_cols),
    .cnt   (col_cnt),
    .hit_c (col_hit_c)
  );

  assign hit = cfg_en ? (row_hit_c && col_hit_c) : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:    if (!fv_i) state_nxt = IDLE;
      IDLE:    if (fv_i)  state_nxt = FRAME;
      FRAME:   if (!fv_i) state_nxt = IDLE;
      default: state_nxt = SYNC;
    endcase
  end

  always_comb begin
    fv_d  = 1'b0;
    lv_d  = 1'b0;
    dat_d = '0;
    if (frame_act) begin
      fv_d = 1'b1;
      lv_d = lv_eff && hit;
      if (lv_d) dat_d = dat_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fv_o         <= 1'b0;
      lv_o         <= 1'b0;
      dat_o        <= '0;
      lv_q         <= 1'b0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      first_len    <= '0;
      len_err      <= 1'b0;
      sh_en        <= 1'b0;
      sh_row_start <= '0;
      sh_rows      <= '0;
      sh_col_start <= '0;
      sh_cols      <= '0;
      meas_rows    <= '0;
      meas_cols    <= '0;
      meas_valid   <= 1'b0;
      line_len_err <= 1'b0;
    end else begin
      fv_o    <= fv_d;
      lv_o    <= lv_d;
      dat_o   <= dat_d;
      lv_q    <= lv_eff;
      col_cnt <= lv_eff ? col_inc : '0;
      if (!frame_act)    row_cnt <= '0;
      else if (line_end) row_cnt <= row_inc;
      if (frame_start) begin
        sh_en        <= crop_en;
        sh_row_start <= crop_row_start;
        sh_rows      <= crop_rows;
        sh_col_start <= crop_col_start;
        sh_cols      <= crop_cols;
        first_len    <= '0;
        len_err      <= 1'b0;
      end else begin
        if (line_end && (row_cnt == '0)) first_len <= col_cnt;
        if (mismatch) len_err <= 1'b1;
      end
      meas_valid <= frame_end;
      // Measurement includes a line that ends on this very cycle.
      if (frame_end) begin
        meas_rows    <= line_end ? row_inc : row_cnt;
        meas_cols    <= (line_end && (row_cnt == '0)) ? col_cnt : first_len;
        line_len_err <= len_err || mismatch;
      end
    end
  end

`ifdef IMAGER_CROP_CHECKSUM_EN
  logic [31:0] cs, cs_nxt;

  assign cs_nxt = lv_o ? ({cs[30:0], cs[31]} ^ 32'(dat_o)) : cs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs            <= '0;
      crop_checksum <= '0;
    end else begin
      cs <= frame_start ? '0 : cs_nxt;
      if (frame_end) crop_checksum <= cs_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_imager_crop.sv
// Directed bench for imager_crop: drives synthetic frames and scoreboards the cropped stream and measurements.
module tb_imager_crop;

  localparam int unsigned DW = 10;
  localparam int unsigned RWD = 12;
  localparam int unsigned CWD = 12;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           crop_en = 1'b0;
  logic [RWD-1:0] crop_row_start = '0;
  logic [RWD-1:0] crop_rows = '0;
  logic [CWD-1:0] crop_col_start = '0;
  logic [CWD-1:0] crop_cols = '0;
  logic [DW-1:0]  dat_i = '0;
  logic           fv_i = 1'b0;
  logic           lv_i = 1'b0;
  logic [DW-1:0]  dat_o;
  logic           fv_o, lv_o, meas_valid, line_len_err;
  logic [RWD:0]   meas_rows;
  logic [CWD:0]   meas_cols;
`ifdef IMAGER_CROP_CHECKSUM_EN
  logic [31:0]    crop_checksum;
`endif

  imager_crop dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .crop_en        (crop_en),
    .crop_row_start (crop_row_start),
    .crop_rows      (crop_rows),
    .crop_col_start (crop_col_start),
    .crop_cols      (crop_cols),
    .dat_i          (dat_i),
    .fv_i           (fv_i),
    .lv_i           (lv_i),
    .dat_o          (dat_o),
    .fv_o           (fv_o),
    .lv_o           (lv_o),
    .meas_rows      (meas_rows),
    .meas_cols      (meas_cols),
    .meas_valid     (meas_valid),
    .line_len_err   (line_len_err)
`ifdef IMAGER_CROP_CHECKSUM_EN
    ,
    .crop_checksum  (crop_checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    longint stamp;
    int     dat;
  } exp_t;

  exp_t   q[$];
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples outputs just after each rising edge.
  int          mon_fv = 0, mon_lines = 0, mon_extra = 0, mon_zero = 0, mon_meas = 0;
  logic        mon_lv_prev = 1'b0;
  longint      mon_rows = 0, mon_cols = 0, mon_err = 0, mon_cs = 0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (reset_n) begin
      if (fv_o) mon_fv++;
      if (lv_o && !mon_lv_prev) mon_lines++;
      mon_lv_prev = lv_o;
      if (lv_o) begin
        if (q.size() == 0) mon_extra++;
        else begin
          e = q.pop_front();
          check("pix_dat", longint'(dat_o), longint'(e.dat));
          check("pix_lat", cyc, e.stamp);
        end
      end else if (dat_o != '0) mon_zero++;
      if (meas_valid) begin
        mon_meas++;
        mon_rows = longint'(meas_rows);
        mon_cols = longint'(meas_cols);
        mon_err  = longint'(line_len_err);
`ifdef IMAGER_CROP_CHECKSUM_EN
        mon_cs   = longint'(crop_checksum);
`endif
      end
    end
  end

  int   exp_fv = 0;
  logic exp_on = 1'b1;
  int   pix_seq = 0;
  int   nxt_en = 0, nxt_rs = 0, nxt_nr = 0, nxt_cs = 0, nxt_nc = 0;

  task automatic drive(input logic fv, input logic lv, input int d);
    @(negedge clk);
    fv_i  = fv;
    lv_i  = lv;
    dat_i = DW'(d);
    if (fv && exp_on) exp_fv++;
  endtask

  task automatic set_cfg(input int en, input int rs, input int nr, input int cs, input int nc);
    crop_en        = 1'(en);
    crop_row_start = RWD'(rs);
    crop_rows      = RWD'(nr);
    crop_col_start = CWD'(cs);
    crop_cols      = CWD'(nc);
  endtask

  task automatic run_frame(input int rows, input int cols, input int short_row,
                           input int chg_row, input int rst_row, input string name);
    int          m_en, m_rs, m_nr, m_cs, m_nc, lines_exp, len, d;
    logic        kept, any;
    logic [31:0] cs_m;
    m_en = int'(crop_en);  m_rs = int'(crop_row_start); m_nr = int'(crop_rows);
    m_cs = int'(crop_col_start); m_nc = int'(crop_cols);
    lines_exp = 0; cs_m = '0;
    exp_on = 1'b1; exp_fv = 0;
    mon_fv = 0; mon_lines = 0; mon_extra = 0; mon_zero = 0; mon_meas = 0;
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int r = 0; r < rows; r++) begin
      if (r == rst_row) begin
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check({name, "_rst_fv"}, longint'(fv_o), 0);
        check({name, "_rst_lv"}, longint'(lv_o), 0);
        check({name, "_rst_dat"}, longint'(dat_o), 0);
        check({name, "_rst_rows"}, longint'(meas_rows), 0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_on = 1'b0; exp_fv = 0; lines_exp = 0;
        mon_fv = 0; mon_lines = 0;
      end
      if (r == chg_row) set_cfg(nxt_en, nxt_rs, nxt_nr, nxt_cs, nxt_nc);
      len = (r == short_row) ? cols - 1 : cols;
      any = 1'b0;
      for (int c = 0; c < len; c++) begin
        kept = exp_on && ((m_en == 0) ||
               (r >= m_rs && r < m_rs + m_nr && c >= m_cs && c < m_cs + m_nc));
        pix_seq++;
        d = pix_seq & 1023;
        drive(1, 1, d);
        if (kept) begin
          q.push_back('{stamp: cyc + 1, dat: d});
          cs_m = {cs_m[30:0], cs_m[31]} ^ 32'(d);
          any = 1'b1;
        end
      end
      if (any) lines_exp++;
      repeat (3) drive(1, 0, 0);
    end
    repeat (6) drive(0, 0, 0);
    check({name, "_fv_cycles"}, mon_fv, exp_fv);
    check({name, "_lines"}, mon_lines, lines_exp);
    check({name, "_extra_pix"}, mon_extra, 0);
    check({name, "_missing_pix"}, q.size(), 0);
    check({name, "_dat_zero"}, mon_zero, 0);
    q.delete();
    if (rst_row < 0) begin
      check({name, "_meas_valid"}, mon_meas, 1);
      check({name, "_meas_rows"}, mon_rows, rows);
      check({name, "_meas_cols"}, mon_cols, (short_row == 0) ? cols - 1 : cols);
      check({name, "_len_err"}, mon_err, (short_row > 0 && short_row < rows) ? 1 : 0);
`ifdef IMAGER_CROP_CHECKSUM_EN
      check({name, "_checksum"}, mon_cs, longint'(cs_m));
`endif
    end else begin
      check({name, "_meas_valid"}, mon_meas, 0);
      check({name, "_meas_rows"}, longint'(meas_rows), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_fv", longint'(fv_o), 0);
    check("reset_lv", longint'(lv_o), 0);
    check("reset_dat", longint'(dat_o), 0);
    check("reset_meas_rows", longint'(meas_rows), 0);
    check("reset_meas_cols", longint'(meas_cols), 0);
    check("reset_meas_valid", longint'(meas_valid), 0);
    check("reset_len_err", longint'(line_len_err), 0);
    reset_n = 1'b1;
    repeat (3) drive(0, 0, 0);

    set_cfg(0, 0, 0, 0, 0);
    run_frame(8, 16, -1, -1, -1, "bypass");

    set_cfg(1, 2, 4, 4, 8);
    run_frame(8, 16, -1, -1, -1, "window");

    set_cfg(1, 0, 8, 12, 10);
    run_frame(8, 16, -1, -1, -1, "col_edge");
    set_cfg(1, 6, 5, 0, 16);
    run_frame(8, 16, -1, -1, -1, "row_edge");
    set_cfg(1, 0, 0, 0, 16);
    run_frame(8, 16, -1, -1, -1, "zero_rows");

    set_cfg(1, 1, 3, 2, 5);
    nxt_en = 1; nxt_rs = 0; nxt_nr = 8; nxt_cs = 0; nxt_nc = 3;
    run_frame(8, 16, -1, 3, -1, "mid_change");
    run_frame(8, 16, -1, -1, -1, "new_cfg");

    set_cfg(0, 0, 0, 0, 0);
    run_frame(8, 16, -1, -1, 3, "reset_mid");
    run_frame(8, 16, -1, -1, -1, "post_reset");

    run_frame(8, 16, 3, -1, -1, "short_line");
    run_frame(8, 16, -1, -1, -1, "err_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
